packet_hex_feeder: RTL and testbench
====================================

Name: packet_hex_feeder

Overview:
- Source side of the six-digit segment interface consumed by the VGA packet display.
- Takes a byte-wide packet stream with a valid/ready handshake and captures three bytes at a fixed offset into each packet.
- Converts each captured nibble to a seven-segment code and drives hex1..hex6.
- Updates its outputs only at a VGA frame boundary, so the display never tears mid-frame.

Parameters:
- OFFSET, 0: index of the first captured byte within a packet; legal range 0..252.
- MIN_FRAMES, 1: minimum number of frame boundaries a committed value stays on screen before the next commit; legal range 1..255.

Ports:
- clk50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pkt_data  in  8  stream byte.
- pkt_valid  in  1  byte present.
- pkt_sop  in  1  first byte of packet; qualified by pkt_valid.
- pkt_eop  in  1  last byte of packet; qualified by pkt_valid.
- pkt_ready  out  1  block can accept a byte.
- vsync_n  in  1  VGA vertical sync, active low, synchronous to clk50.
- hex1..hex6  out  8 each  segment codes: bit0=a .. bit6=g, bit7=dp.

Behaviour:
- Handshake:
  - A beat transfers on a rising clk50 edge where pkt_valid & pkt_ready.
  - The source holds data and flags until the beat transfers.
- Reset (reset_n=0):
  - state=IDLE, pkt_ready=1, hex1..hex6=8'h3F ("0"), shadow registers=8'h3F.
  - byte counter=0, hold_cnt=0, vs_q=1.
- Nibble encoding, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Digit mapping for captured byte k (k=0..2):
  - high nibble goes to hex(k+1), low nibble goes to hex(k+4).
  - With OFFSET=0, bytes 12 34 56 give hex1=1, hex2=3, hex3=5, hex4=2, hex5=4, hex6=6.
- Byte counter: 8 bits, saturates at 255, reset to 0 by every accepted sop beat.
  - Packet byte index = counter value at transfer; the sop beat is index 0.
- State machine:
  - IDLE, pkt_ready=1:
    - Beats without sop are accepted and dropped.
    - A sop beat starts a packet and enters CAPTURE.
    - sop&eop on the same beat is a one-byte packet: process it as index 0, then run end-of-packet handling immediately.
  - CAPTURE, pkt_ready=1:
    - A beat with index in OFFSET..OFFSET+2 writes the encoded nibbles into the shadow registers.
    - A sop beat mid-packet abandons the current packet, restarts at index 0 and stays in CAPTURE; the shadow is re-initialised as for a new packet.
  - End of packet (accepted eop beat):
    - All three bytes captured: shadow bit7 all 0.
    - Short packet: uncaptured digits = 8'h40 ("-") and shadow hex6 bit7=1 (e.g. 8'hC0 if hex6 itself uncaptured).
    - Either way, go to HOLD.
  - HOLD, pkt_ready=0: wait for a commit.
- Shadow initialisation: on every sop beat all six shadow digits are set to 8'h40 before capture; the capture on that same beat still applies.
- Frame edge:
  - vs_q <= vsync_n each cycle.
  - frame_edge = vs_q & ~vsync_n, a combinational one-cycle pulse.
  - A sustained low vsync_n gives exactly one edge.
- Commit:
  - Condition: state==HOLD & frame_edge & hold_cnt==0.
  - On that same clk50 edge: hex1..hex6 <= shadow, hold_cnt <= MIN_FRAMES-1, state <= IDLE.
  - pkt_ready returns to 1 the following cycle.
- hold_cnt update:
  - Each frame_edge with hold_cnt!=0 and no commit decrements hold_cnt, in any state.
  - A frame_edge in HOLD with hold_cnt!=0 only decrements; no commit.
- hex outputs change only on a commit or on reset.
- Latency: at most 1+MIN_FRAMES frame edges from eop to display.
- Reset mid-packet or in HOLD: the partial or pending packet is discarded and outputs return to the reset values immediately (asynchronous).

Test Plan:
- Display after reset:
  - reset_n low then high, no traffic -> hex1..hex6=8'h3F, pkt_ready=1.
  - Toggle vsync_n for 3 frames -> no output change.
- Full packet, OFFSET=0, MIN_FRAMES=1:
  - Send sop 12, 34, 56, eop 78 -> pkt_ready=0 after the eop beat; outputs unchanged until the vsync_n fall.
  - At the fall -> hex1..6 = 06,4F,6D,5B,66,7D and pkt_ready=1 the next cycle.
- Short packet:
  - Send single beat sop&eop A5 -> commit gives hex1=77, hex4=6D, hex2=hex3=hex5=40, hex6=C0.
- Mid-packet sop:
  - Send sop FF, FF, then sop 01 23 45 eop -> hex1..6 = 3F,5B,66,06,4F,6D.
  - The FF bytes never appear.
- OFFSET=2, MIN_FRAMES=3:
  - Two back-to-back 6-byte packets (00 00 AB CD EF 00 / 00 00 11 22 33 00).
  - -> first commits at the next frame edge; the second commits exactly 3 frame edges later.
  - pkt_ready stays low while the second packet is in HOLD.
- Reset in HOLD:
  - Assert reset_n low with a pending packet -> hex=3F immediately, pkt_ready=1.
  - No commit at the next frame edge.

Source files
------------

// File: rtl/packet_hex_if.sv
// Byte-wide packet stream with a valid/ready handshake.
// master: stream source (drives data, valid, sop, eop; samples ready)
// slave : stream sink   (samples data, valid, sop, eop; drives ready)
interface packet_hex_if;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_sop;
    logic       pkt_eop;
    logic       pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        output pkt_sop,
        output pkt_eop,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        input  pkt_sop,
        input  pkt_eop,
        output pkt_ready
    );
endinterface

// File: rtl/packet_hex_feeder.sv
// packet_hex_feeder
// Captures three bytes at a fixed offset into each packet of a byte stream,
// converts the six nibbles to seven-segment codes and presents them on
// hex1..hex6. New values are committed only on a falling edge of vsync_n so
// the display never changes mid-frame, and each committed value is held for
// at least MIN_FRAMES frame boundaries.
//
// Ports:
//   clk50      system clock
//   reset_n    asynchronous active-low reset
//   pkt        packet stream sink (data, valid, sop, eop in; ready out)
//   vsync_n    VGA vertical sync, active low, synchronous to clk50
//   hex1..hex6 segment codes, bit0=a .. bit6=g, bit7=dp
//
// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | no packet in progress; non-sop beats are dropped
// CAPT  | inside a packet; beats at OFFSET..OFFSET+2 fill the shadow digits
// HOLD  | packet complete; stream stalled until the next allowed commit
module packet_hex_feeder #(
    parameter int unsigned OFFSET     = 0,
    parameter int unsigned MIN_FRAMES = 1
) (
    input  logic             clk50,
    input  logic             reset_n,
    packet_hex_if.slave      pkt,
    input  logic             vsync_n,
    output logic [7:0]       hex1,
    output logic [7:0]       hex2,
    output logic [7:0]       hex3,
    output logic [7:0]       hex4,
    output logic [7:0]       hex5,
    output logic [7:0]       hex6
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [8:0] OFF_W     = 9'(OFFSET);
    localparam logic [7:0] HOLD_INIT = 8'(MIN_FRAMES - 1);
    localparam logic [7:0] SEG_ZERO  = 8'h3F;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       vs_q;
    logic [2:0] cap_q, cap_d;
    logic [7:0] shadow_q [6];
    logic [7:0] shadow_d [6];
    logic [7:0] disp_q [6];
    logic [7:0] disp_d [6];

    logic       frame_edge;
    logic       commit;
    logic       accept;
    logic       in_pkt;
    logic [7:0] beat_idx;
    logic [8:0] rel_idx;
    logic       cap_hit;

    assign pkt.pkt_ready = (state_q != S_HOLD);
    assign frame_edge    = vs_q & ~vsync_n;
    assign commit        = (state_q == S_HOLD) & frame_edge & (hold_q == 8'd0);
    assign accept        = pkt.pkt_valid & pkt.pkt_ready;
    // A sop beat always belongs to a packet, even one that restarts mid-packet.
    assign in_pkt        = pkt.pkt_sop | (state_q == S_CAPT);
    assign beat_idx      = pkt.pkt_sop ? 8'd0 : cnt_q;
    // Indices below OFFSET wrap to large values in 9 bits, so one compare
    // covers both ends of the capture window.
    assign rel_idx       = {1'b0, beat_idx} - OFF_W;
    assign cap_hit       = (rel_idx < 9'd3);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        cap_d    = cap_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;

        if (commit) begin
            disp_d  = shadow_q;
            hold_d  = HOLD_INIT;
            state_d = S_IDLE;
        end else if (frame_edge && (hold_q != 8'd0)) begin
            hold_d = hold_q - 8'd1;
        end

        if (accept && in_pkt) begin
            state_d = S_CAPT;
            cnt_d   = (beat_idx == 8'hFF) ? 8'hFF : beat_idx + 8'd1;
            if (pkt.pkt_sop) begin
                for (int i = 0; i < 6; i++) begin
                    shadow_d[i] = SEG_DASH;
                end
                cap_d = 3'b000;
            end
            if (cap_hit) begin
                for (int k = 0; k < 3; k++) begin
                    if (rel_idx[1:0] == 2'(k)) begin
                        shadow_d[k]     = seg_enc(pkt.pkt_data[7:4]);
                        shadow_d[k + 3] = seg_enc(pkt.pkt_data[3:0]);
                        cap_d[k]        = 1'b1;
                    end
                end
            end
            if (pkt.pkt_eop) begin
                // The decimal point on hex6 flags a packet too short to fill all digits.
                shadow_d[5][7] = ~&cap_d;
                state_d        = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            hold_q  <= 8'd0;
            vs_q    <= 1'b1;
            cap_q   <= 3'b000;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= SEG_ZERO;
                disp_q[i]   <= SEG_ZERO;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            vs_q     <= vsync_n;
            cap_q    <= cap_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    assign hex1 = disp_q[0];
    assign hex2 = disp_q[1];
    assign hex3 = disp_q[2];
    assign hex4 = disp_q[3];
    assign hex5 = disp_q[4];
    assign hex6 = disp_q[5];

endmodule

// File: tb/tb_packet_hex_feeder.sv
module tb_packet_hex_feeder;

    logic clk50   = 1'b0;
    logic reset_n = 1'b0;
    logic vsync_n = 1'b1;
    always #5 clk50 = ~clk50;

    int total = 0;
    int bad   = 0;

    localparam int OFFS [2] = '{0, 2};
    localparam int MINF [2] = '{1, 3};
    localparam logic [7:0] SEG_T [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    packet_hex_if if0 ();
    packet_hex_if if1 ();

    logic [7:0] drv_data  [2];
    logic       drv_valid [2];
    logic       drv_sop   [2];
    logic       drv_eop   [2];
    logic       rdy       [2];
    logic [7:0] hx [2][6];

    assign if0.pkt_data  = drv_data[0];
    assign if0.pkt_valid = drv_valid[0];
    assign if0.pkt_sop   = drv_sop[0];
    assign if0.pkt_eop   = drv_eop[0];
    assign rdy[0]        = if0.pkt_ready;
    assign if1.pkt_data  = drv_data[1];
    assign if1.pkt_valid = drv_valid[1];
    assign if1.pkt_sop   = drv_sop[1];
    assign if1.pkt_eop   = drv_eop[1];
    assign rdy[1]        = if1.pkt_ready;

    packet_hex_feeder #(.OFFSET(0), .MIN_FRAMES(1)) dut0 (
        .clk50(clk50), .reset_n(reset_n), .pkt(if0), .vsync_n(vsync_n),
        .hex1(hx[0][0]), .hex2(hx[0][1]), .hex3(hx[0][2]),
        .hex4(hx[0][3]), .hex5(hx[0][4]), .hex6(hx[0][5])
    );

    packet_hex_feeder #(.OFFSET(2), .MIN_FRAMES(3)) dut1 (
        .clk50(clk50), .reset_n(reset_n), .pkt(if1), .vsync_n(vsync_n),
        .hex1(hx[1][0]), .hex2(hx[1][1]), .hex3(hx[1][2]),
        .hex4(hx[1][3]), .hex5(hx[1][4]), .hex6(hx[1][5])
    );

    // Behavioural model: tracks packet contents by byte index and what is on screen.
    bit         m_in_pkt  [2];
    int         m_cnt     [2];
    logic [7:0] m_cap     [2][3];
    bit         m_pending [2];
    logic [7:0] m_pend    [2][6];
    logic [7:0] m_disp    [2][6];
    int         m_hold    [2];
    bit         m_acc     [2];
    bit         m_vs_prev;

    task automatic model_reset();
        m_vs_prev = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_in_pkt[d]  = 1'b0;
            m_cnt[d]     = 0;
            m_pending[d] = 1'b0;
            m_hold[d]    = 0;
            m_acc[d]     = 1'b0;
            for (int i = 0; i < 6; i++) m_disp[d][i] = 8'h3F;
        end
    endtask

    task automatic model_step();
        bit fe;
        bit acc;
        int idx;
        int len;
        fe = m_vs_prev && !vsync_n;
        m_vs_prev = vsync_n;
        for (int d = 0; d < 2; d++) begin
            acc = drv_valid[d] && !m_pending[d];
            m_acc[d] = acc;
            if (m_pending[d] && fe && m_hold[d] == 0) begin
                for (int i = 0; i < 6; i++) m_disp[d][i] = m_pend[d][i];
                m_pending[d] = 1'b0;
                m_hold[d] = MINF[d] - 1;
            end else if (fe && m_hold[d] > 0) begin
                m_hold[d]--;
            end
            if (acc) begin
                if (drv_sop[d]) begin
                    m_in_pkt[d] = 1'b1;
                    idx = 0;
                end else begin
                    idx = m_cnt[d];
                end
                if (m_in_pkt[d]) begin
                    if (idx >= OFFS[d] && idx < OFFS[d] + 3) m_cap[d][idx - OFFS[d]] = drv_data[d];
                    m_cnt[d] = (idx + 1 > 255) ? 255 : idx + 1;
                    if (drv_eop[d]) begin
                        len = idx + 1;
                        for (int k = 0; k < 3; k++) begin
                            if (OFFS[d] + k < len) begin
                                m_pend[d][k]     = SEG_T[m_cap[d][k][7:4]];
                                m_pend[d][k + 3] = SEG_T[m_cap[d][k][3:0]];
                            end else begin
                                m_pend[d][k]     = 8'h40;
                                m_pend[d][k + 3] = 8'h40;
                            end
                        end
                        if (len < OFFS[d] + 3) m_pend[d][5][7] = 1'b1;
                        m_pending[d] = 1'b1;
                        m_in_pkt[d]  = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk50 or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] dut_hex(input int d);
        return {hx[d][0], hx[d][1], hx[d][2], hx[d][3], hx[d][4], hx[d][5]};
    endfunction

    function automatic logic [47:0] mdl_hex(input int d);
        return {m_disp[d][0], m_disp[d][1], m_disp[d][2], m_disp[d][3], m_disp[d][4], m_disp[d][5]};
    endfunction

    // Continuous compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk50);
            if (reset_n) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("hex_dut%0d", d), dut_hex(d), mdl_hex(d));
                    chk($sformatf("ready_dut%0d", d), 48'(rdy[d]), 48'(!m_pending[d]));
                end
            end
        end
    end

    // Caller sits at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input int d, input logic [7:0] data, input bit sop, input bit eop);
        int n;
        drv_data[d]  = data;
        drv_sop[d]   = sop;
        drv_eop[d]   = eop;
        drv_valid[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!m_acc[d] && n < 400);
        if (!m_acc[d]) chk("beat_timeout", 48'(0), 48'(1));
        drv_valid[d] = 1'b0;
        drv_sop[d]   = 1'b0;
        drv_eop[d]   = 1'b0;
    endtask

    task automatic frame();
        vsync_n = 1'b0;
        repeat (3) @(negedge clk50);
        vsync_n = 1'b1;
        repeat (3) @(negedge clk50);
    endtask

    bit rnd_done = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            drv_data[d] = 8'h00; drv_valid[d] = 1'b0; drv_sop[d] = 1'b0; drv_eop[d] = 1'b0;
        end
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        @(negedge clk50);
        chk("reset_hex0", dut_hex(0), {6{8'h3F}});
        chk("reset_hex1", dut_hex(1), {6{8'h3F}});
        chk("reset_ready0", 48'(rdy[0]), 48'(1));
        repeat (3) frame();
        chk("idle_frames_hex0", dut_hex(0), {6{8'h3F}});

        // Full packet on OFFSET=0
        send_beat(0, 8'h12, 1, 0);
        send_beat(0, 8'h34, 0, 0);
        send_beat(0, 8'h56, 0, 0);
        send_beat(0, 8'h78, 0, 1);
        chk("full_ready_low", 48'(rdy[0]), 48'(0));
        repeat (3) @(negedge clk50);
        chk("full_before_frame", dut_hex(0), {6{8'h3F}});
        frame();
        chk("full_commit", dut_hex(0), {8'h06, 8'h4F, 8'h6D, 8'h5B, 8'h66, 8'h7D});
        chk("full_ready_back", 48'(rdy[0]), 48'(1));

        // One-byte packet
        send_beat(0, 8'hA5, 1, 1);
        frame();
        chk("short_commit", dut_hex(0), {8'h77, 8'h40, 8'h40, 8'h6D, 8'h40, 8'hC0});

        // Restart mid-packet
        send_beat(0, 8'hFF, 1, 0);
        send_beat(0, 8'hFF, 0, 0);
        send_beat(0, 8'h01, 1, 0);
        send_beat(0, 8'h23, 0, 0);
        send_beat(0, 8'h45, 0, 1);
        frame();
        chk("midsop_commit", dut_hex(0), {8'h3F, 8'h5B, 8'h66, 8'h06, 8'h4F, 8'h6D});

        // OFFSET=2, MIN_FRAMES=3: back-to-back packets
        send_beat(1, 8'h00, 1, 0);
        send_beat(1, 8'h00, 0, 0);
        send_beat(1, 8'hAB, 0, 0);
        send_beat(1, 8'hCD, 0, 0);
        send_beat(1, 8'hEF, 0, 0);
        send_beat(1, 8'h00, 0, 1);
        frame();
        chk("off2_first", dut_hex(1), {8'h77, 8'h39, 8'h79, 8'h7C, 8'h5E, 8'h71});
        send_beat(1, 8'h00, 1, 0);
        send_beat(1, 8'h00, 0, 0);
        send_beat(1, 8'h11, 0, 0);
        send_beat(1, 8'h22, 0, 0);
        send_beat(1, 8'h33, 0, 0);
        send_beat(1, 8'h00, 0, 1);
        frame();
        frame();
        chk("off2_held", dut_hex(1), {8'h77, 8'h39, 8'h79, 8'h7C, 8'h5E, 8'h71});
        chk("off2_ready_low", 48'(rdy[1]), 48'(0));
        frame();
        chk("off2_second", dut_hex(1), {8'h06, 8'h5B, 8'h4F, 8'h06, 8'h5B, 8'h4F});

        // Reset with a packet pending in HOLD
        send_beat(0, 8'h9A, 1, 0);
        send_beat(0, 8'hBC, 0, 0);
        send_beat(0, 8'hDE, 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_hold_hex", dut_hex(0), {6{8'h3F}});
        chk("rst_hold_ready", 48'(rdy[0]), 48'(1));
        @(negedge clk50);
        reset_n = 1'b1;
        frame();
        chk("rst_no_commit", dut_hex(0), {6{8'h3F}});

        // Randomized traffic against the model
        fork
            begin
                while (!rnd_done) begin
                    repeat ($urandom_range(6, 20)) @(negedge clk50);
                    vsync_n = 1'b0;
                    repeat ($urandom_range(1, 4)) @(negedge clk50);
                    vsync_n = 1'b1;
                end
            end
            begin
                for (int it = 0; it < 60; it++) begin
                    int d;
                    int len;
                    d   = int'($urandom_range(0, 1));
                    len = int'($urandom_range(1, 8));
                    if ($urandom_range(0, 3) == 0) send_beat(d, 8'($urandom), 0, 0);
                    for (int i = 0; i < len; i++) begin
                        bit s;
                        s = (i == 0) || ($urandom_range(0, 9) == 0);
                        send_beat(d, 8'($urandom), s, i == len - 1);
                        if ($urandom_range(0, 3) == 0) @(negedge clk50);
                    end
                end
                rnd_done = 1'b1;
            end
        join
        repeat (5) @(negedge clk50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
